// File: rtl/addcmp_pkg.sv
// Shared types for the addcmp_pipe slice: operand/result bundles and the fixed
// datapath width of the AddCmp50 core.
package addcmp_pkg;

  localparam int ADDCMP_W     = 50;
  localparam int ADDCMP_TAG_W = 8;

  typedef struct packed {
    logic [ADDCMP_W-1:0]     a;
    logic [ADDCMP_W-1:0]     b;
    logic [ADDCMP_W-1:0]     c;
    logic [ADDCMP_TAG_W-1:0] tag;
  } addcmp_operands_t;

  typedef struct packed {
    logic                    eq;
    logic [ADDCMP_TAG_W-1:0] tag;
  } addcmp_result_t;

endpackage

// File: rtl/AddCmp50.sv
// 50-bit adder-comparator core: o_eq is 1 when (i_a + i_b) mod 2^50 equals i_c.
// Purely combinational; the carry-out of the sum is discarded.
module AddCmp50
  import addcmp_pkg::*;
(
  input  logic [ADDCMP_W-1:0] i_a,
  input  logic [ADDCMP_W-1:0] i_b,
  input  logic [ADDCMP_W-1:0] i_c,
  output logic                o_eq
);

  logic [ADDCMP_W-1:0] w_sum;

  assign w_sum = i_a + i_b;
  assign o_eq  = (w_sum == i_c);

endmodule

// File: rtl/addcmp_pipe.sv
// Two-stage valid/ready wrapper around AddCmp50 (operand register, result register).
// Optional saturating match statistics are built when ADDCMP_PIPE_STATS_EN is defined.
module addcmp_pipe
  import addcmp_pkg::*;
#(
  parameter int W     = 50,
  parameter int TAG_W = 8,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [W-1:0]     in_c,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_eq,
  output logic [TAG_W-1:0] out_tag,
  input  logic             stat_clr,
  output logic [CNT_W-1:0] stat_total,
  output logic [CNT_W-1:0] stat_match
);

  if (W != ADDCMP_W) begin : g_w_check
    $error("addcmp_pipe: W must be 50");
  end
  if (TAG_W != ADDCMP_TAG_W) begin : g_tag_check
    $error("addcmp_pipe: TAG_W must match addcmp_pkg::ADDCMP_TAG_W");
  end

  logic             r_s1_v;
  addcmp_operands_t r_s1_ops;
  logic             r_s2_v;
  addcmp_result_t   r_s2_res;

  logic w_s2_adv;
  logic w_in_ready;
  logic w_eq;
  logic w_done;

  // S2 frees up when empty or draining; S1 may then load even while full.
  assign w_s2_adv   = !r_s2_v || out_ready;
  assign w_in_ready = !r_s1_v || w_s2_adv;
  assign w_done     = r_s2_v && out_ready;

  AddCmp50 u_core (
    .i_a  (r_s1_ops.a),
    .i_b  (r_s1_ops.b),
    .i_c  (r_s1_ops.c),
    .o_eq (w_eq)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_v <= 1'b0;
    end else if (w_in_ready) begin
      r_s1_v <= in_valid;
    end else begin
      r_s1_v <= r_s1_v;
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid && w_in_ready) begin
      r_s1_ops <= '{a: in_a, b: in_b, c: in_c, tag: in_tag};
    end else begin
      r_s1_ops <= r_s1_ops;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_v   <= 1'b0;
      r_s2_res <= '{eq: 1'b0, tag: {ADDCMP_TAG_W{1'b0}}};
    end else if (w_s2_adv) begin
      r_s2_v <= r_s1_v;
      if (r_s1_v) begin
        r_s2_res <= '{eq: w_eq, tag: r_s1_ops.tag};
      end else begin
        r_s2_res <= r_s2_res;
      end
    end else begin
      r_s2_v   <= r_s2_v;
      r_s2_res <= r_s2_res;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_s2_v;
  assign out_eq    = r_s2_res.eq;
  assign out_tag   = r_s2_res.tag;

`ifdef ADDCMP_PIPE_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_stat_total;
  logic [CNT_W-1:0] r_stat_match;

  // Clear wins over a same-cycle completion; both counters stick at all-ones.
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      r_stat_total <= {CNT_W{1'b0}};
      r_stat_match <= {CNT_W{1'b0}};
    end else if (w_done) begin
      r_stat_total <= (r_stat_total == CNT_MAX) ? r_stat_total : r_stat_total + CNT_ONE;
      if (r_s2_res.eq && (r_stat_match != CNT_MAX)) begin
        r_stat_match <= r_stat_match + CNT_ONE;
      end else begin
        r_stat_match <= r_stat_match;
      end
    end else begin
      r_stat_total <= r_stat_total;
      r_stat_match <= r_stat_match;
    end
  end

  assign stat_total = r_stat_total;
  assign stat_match = r_stat_match;
`else
  logic w_unused_stats;

  assign w_unused_stats = stat_clr ^ w_done;
  assign stat_total     = {CNT_W{1'b0}};
  assign stat_match     = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_addcmp_pipe.sv
// Directed self-checking bench for addcmp_pipe; statistics expectations follow
// whether ADDCMP_PIPE_STATS_EN is defined for the build.
module tb_addcmp_pipe;

  localparam int W     = 50;
  localparam int TAG_W = 8;
  localparam int CNT_W = 32;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic [W-1:0]     in_c;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic             out_eq;
  logic [TAG_W-1:0] out_tag;
  logic             stat_clr;
  logic [CNT_W-1:0] stat_total;
  logic [CNT_W-1:0] stat_match;

  int n_checks = 0;
  int n_fail   = 0;

  addcmp_pipe #(.W(W), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_c       (in_c),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_eq     (out_eq),
    .out_tag    (out_tag),
    .stat_clr   (stat_clr),
    .stat_total (stat_total),
    .stat_match (stat_match)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; stat_clr = 1'b0;
    in_a = 50'd0; in_b = 50'd0; in_c = 50'd0; in_tag = 8'd0;
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++;
    if (out_eq !== 1'b0 || out_tag !== 8'h00) begin
      n_fail++; $display("FAIL reset_out_data got eq=%b tag=%h want eq=0 tag=00", out_eq, out_tag);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_checks++;
    if (stat_total !== 32'd0 || stat_match !== 32'd0) begin
      n_fail++; $display("FAIL reset_stats got total=%0d match=%0d want 0/0", stat_total, stat_match);
    end
    tick();
  endtask

  task automatic test_basic();
    in_valid = 1'b1; in_a = 50'd3; in_b = 50'd4; in_c = 50'd7; in_tag = 8'h11; out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_accept got in_ready=%b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_latency1 got out_valid=%b want 0", out_valid); end
    tick();
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || out_eq !== 1'b1 || out_tag !== 8'h11) begin
      n_fail++; $display("FAIL basic_result got v=%b eq=%b tag=%h want v=1 eq=1 tag=11", out_valid, out_eq, out_tag);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain got out_valid=%b want 0", out_valid); end
    tick();
  endtask

  task automatic test_mismatch_wrap();
    logic [W-1:0] va [3];
    logic [W-1:0] vb [3];
    logic [W-1:0] vc [3];
    logic         ve [3];
    va[0] = 50'd5;          vb[0] = 50'd6;          vc[0] = 50'd12;         ve[0] = 1'b0;
    va[1] = {50{1'b1}};     vb[1] = 50'd1;          vc[1] = 50'd0;          ve[1] = 1'b1;
    va[2] = {50{1'b1}};     vb[2] = {50{1'b1}};     vc[2] = {{49{1'b1}}, 1'b0}; ve[2] = 1'b1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 5; cyc++) begin
      if (cyc < 3) begin
        in_valid = 1'b1; in_a = va[cyc]; in_b = vb[cyc]; in_c = vc[cyc]; in_tag = 8'(8'h40 + cyc);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (cyc >= 2) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_eq !== ve[cyc-2] || out_tag !== 8'(8'h40 + cyc - 2)) begin
          n_fail++;
          $display("FAIL wrap_vec%0d got v=%b eq=%b tag=%h want v=1 eq=%b tag=%h",
                   cyc - 2, out_valid, out_eq, out_tag, ve[cyc-2], 8'(8'h40 + cyc - 2));
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int         next_tag = 1;
    int         got = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_tag = 8'h00;
    logic       exp_rdy;
    for (int cyc = 0; cyc < 40 && got < 10; cyc++) begin
      out_ready = !(cyc >= 3 && cyc <= 7);
      in_valid  = (next_tag <= 10);
      in_a = 50'(next_tag); in_b = 50'd1; in_c = 50'(next_tag + 1); in_tag = 8'(next_tag);
      @(negedge clk);
      if (cyc < 10) begin
        exp_rdy = (cyc < 3) || (cyc > 7);
        n_checks++;
        if (in_ready !== exp_rdy) begin
          n_fail++; $display("FAIL bp_in_ready cyc%0d got %b want %b", cyc, in_ready, exp_rdy);
        end
      end
      if (prev_stall) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_tag !== prev_tag) begin
          n_fail++; $display("FAIL bp_stable cyc%0d got v=%b tag=%h want v=1 tag=%h", cyc, out_valid, out_tag, prev_tag);
        end
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        n_checks++;
        if (out_tag !== 8'(got + 1) || out_eq !== 1'b1) begin
          n_fail++; $display("FAIL bp_order got tag=%h eq=%b want tag=%h eq=1", out_tag, out_eq, 8'(got + 1));
        end
        got++;
      end
      prev_stall = (out_valid === 1'b1) && !out_ready;
      prev_tag   = out_tag;
      if (in_valid && in_ready === 1'b1) next_tag++;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_checks++;
    if (got != 10) begin n_fail++; $display("FAIL bp_count got %0d results want 10", got); end
    tick(); tick();
  endtask

  task automatic test_bubbles();
    logic [5:0] pat = 6'b101101;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      in_valid = (cyc < 6) ? pat[cyc] : 1'b0;
      in_a = 50'd1; in_b = 50'd1; in_c = 50'd2; in_tag = 8'(8'h20 + cyc);
      @(negedge clk);
      if (cyc >= 2) begin
        n_checks++;
        if (out_valid !== pat[cyc-2] || (pat[cyc-2] && out_tag !== 8'(8'h20 + cyc - 2))) begin
          n_fail++;
          $display("FAIL bubble cyc%0d got v=%b tag=%h want v=%b tag=%h",
                   cyc, out_valid, out_tag, pat[cyc-2], 8'(8'h20 + cyc - 2));
        end
      end
      tick();
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 50'd1; in_b = 50'd2; in_c = 50'd3; in_tag = 8'h30;
    tick();
    in_tag = 8'h31;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_full got v=%b rdy=%b want v=1 rdy=0", out_valid, in_ready);
    end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_tag !== 8'h00) begin
      n_fail++; $display("FAIL rstmid_after got v=%b rdy=%b tag=%h want v=0 rdy=1 tag=00", out_valid, in_ready, out_tag);
    end
    n_checks++;
    if (stat_total !== 32'd0 || stat_match !== 32'd0) begin
      n_fail++; $display("FAIL rstmid_stats got total=%0d match=%0d want 0/0", stat_total, stat_match);
    end
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 3; cyc++) begin
      tick();
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_stale cyc%0d got v=%b want 0", cyc, out_valid); end
    end
    tick();
  endtask

  task automatic test_stats();
    logic [W-1:0] va [6];
    logic [W-1:0] vb [6];
    logic [W-1:0] vc [6];
    logic [31:0]  exp_total;
    logic [31:0]  exp_match;
    va[0] = 50'd1;  vb[0] = 50'd1;  vc[0] = 50'd2;
    va[1] = 50'd1;  vb[1] = 50'd1;  vc[1] = 50'd3;
    va[2] = 50'd10; vb[2] = 50'd20; vc[2] = 50'd30;
    va[3] = 50'd0;  vb[3] = 50'd0;  vc[3] = 50'd0;
    va[4] = 50'd7;  vb[4] = 50'd7;  vc[4] = 50'd15;
    va[5] = {50{1'b1}}; vb[5] = 50'd2; vc[5] = 50'd1;
`ifdef ADDCMP_PIPE_STATS_EN
    exp_total = 32'd6; exp_match = 32'd4;
`else
    exp_total = 32'd0; exp_match = 32'd0;
`endif
    out_ready = 1'b1; in_valid = 1'b0; stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    for (int cyc = 0; cyc < 9; cyc++) begin
      if (cyc < 6) begin
        in_valid = 1'b1; in_a = va[cyc]; in_b = vb[cyc]; in_c = vc[cyc]; in_tag = 8'(8'h50 + cyc);
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
    @(negedge clk);
    n_checks++;
    if (stat_total !== exp_total || stat_match !== exp_match) begin
      n_fail++; $display("FAIL stats_count got total=%0d match=%0d want %0d/%0d", stat_total, stat_match, exp_total, exp_match);
    end
    tick();
    in_valid = 1'b1; in_a = 50'd2; in_b = 50'd2; in_c = 50'd4; in_tag = 8'h60;
    tick();
    in_valid = 1'b0;
    tick();
    stat_clr = 1'b1;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stats_clr_setup got v=%b want 1", out_valid); end
    tick();
    stat_clr = 1'b0;
    @(negedge clk);
    n_checks++;
    if (stat_total !== 32'd0 || stat_match !== 32'd0) begin
      n_fail++; $display("FAIL stats_clr_prio got total=%0d match=%0d want 0/0", stat_total, stat_match);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mismatch_wrap();
    test_backpressure();
    test_bubbles();
    test_reset_mid();
    test_stats();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/addcmp_pipe.md
Name: addcmp_pipe

Overview:
- Streaming front/back-end for the 50-bit adder-comparator (AddCmp50).
- Accepts operand triples (a, b, c) over a valid/ready handshake and registers them.
- The registered operands drive AddCmp50; the eq result is captured with its tag and presented on a valid/ready output.
- Full throughput: one triple per cycle under no backpressure. Optional saturating match statistics.

Parameters:
- W, 50, operand width. Must equal 50; elaboration-time check fails otherwise.
- TAG_W, 8, width of the user tag carried alongside each triple.
- CNT_W, 32, width of the statistics counters.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  operand triple valid
- in_ready  out  1  block can accept a triple this cycle
- in_a  in  W  addend a
- in_b  in  W  addend b
- in_c  in  W  compare value c
- in_tag  in  TAG_W  user tag
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_eq  out  1  1 when (a+b) mod 2^W == c
- out_tag  out  TAG_W  tag of the triple that produced out_eq
- stat_clr  in  1  clear statistics counters (sync)
- stat_total  out  CNT_W  completed results
- stat_match  out  CNT_W  completed results with eq=1

Behaviour:
- Stages
  - S1: operand register (a, b, c, tag, s1_v).
  - S2: result register (eq, tag, s2_v).
- Handshake rules
  - s2_adv = !s2_v | out_ready.
  - in_ready = !s1_v | s2_adv. Combinational from out_ready; no combinational path from in_valid to in_ready.
  - S1 loads when in_valid & in_ready; s1_v <= in_valid when in_ready, else holds.
  - S2 loads AddCmp50 eq (from S1 regs) and the S1 tag when s1_v & s2_adv; s2_v <= s1_v when s2_adv, else holds.
- Latency: a triple accepted in cycle N appears on out_valid in cycle N+2 if out_ready was high.
- Output stability: while out_valid & !out_ready, out_eq and out_tag hold stable and S1 holds its contents.
- Arithmetic: the sum is W bits and the carry-out is discarded (modular), e.g. a=2^50-1, b=1, c=0 gives eq=1.
- Reset
  - s1_v=0, s2_v=0, out_valid=0, out_eq=0, out_tag=0, counters=0; in_ready=1 on the first cycle after reset.
  - Reset mid-stream drops in-flight triples with no output produced.
  - Data registers may be non-reset except out_eq/out_tag.
- Full pipeline (both stages valid, out_ready=0): in_ready=0.
- Simultaneous events: with out_ready=1 the pipe accepts and retires in the same cycle. A bubble (in_valid=0) propagates as out_valid=0 two cycles later.
- Statistics: a result is completed when out_valid & out_ready. Counters saturate at 2^CNT_W-1. stat_clr has priority over an increment in the same cycle.

Optional Feature:
- ADDCMP_PIPE_STATS_EN
  - Defined: stat_total/stat_match are implemented as described.
  - Undefined: counters are not built, stat_total=stat_match=0 constantly, and stat_clr is ignored.
  - Ports exist in both builds.

Decomposition:
- Package addcmp_pkg:
  - localparam ADDCMP_W=50.
  - typedef addcmp_operands_t, a struct {a,b,c,tag}.
  - typedef addcmp_result_t, a struct {eq,tag}.
- One sub-module instance: AddCmp50 (existing), driven purely from S1 registers.
- Counters stay inline under the macro.

Test Plan:
- Basic match: a=3, b=4, c=7, tag=0x11, out_ready=1 -> out_valid two cycles after accept; out_eq=1, out_tag=0x11.
- Mismatch and wrap: (5, 6, 12) -> eq=0; (2^50-1, 1, 0) -> eq=1.
- Backpressure:
  - Stimulus: stream tags 1..10 back-to-back, out_ready low for cycles 3-7.
  - Check: in_ready drops once S1 and S2 are full; output stable while stalled.
  - Check: all 10 tags delivered in order, none dropped or duplicated.
- Bubbles: in_valid pattern 1,0,1,1,0,1 with out_ready=1 -> out_valid pattern identical, delayed 2 cycles.
- Reset mid-operation: assert rst with both stages full -> next cycle out_valid=0, in_ready=1, counters=0, no stale result emitted.
- Stats (macro on): 6 results with 4 matches -> stat_total=6, stat_match=4; stat_clr coinciding with a completion -> both 0. Macro off -> both read 0 throughout.
